// File: rtl/srq_rr_pkg.sv
// srq_rr_pkg: width helpers and channel index type shared by the multi-lane queue
package srq_rr_pkg;
    typedef int unsigned ch_idx_t;

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int chw_of(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction
endpackage

// File: rtl/srq_lane.sv
// srq_lane: one compacting shift-register lane; slot 0 is the oldest entry
module srq_lane #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             ready
);
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [CW-1:0]    wr;
    logic [CW-1:0]    cnt_n;

    assign wr         = pop ? count - CW'(1) : count;
    assign cnt_n      = count + CW'(push) - CW'(pop);
    assign head_data  = data[0];
    assign head_valid = vld[0];
    assign ready      = count < CW'(DEPTH);

    // a push in the same cycle as a pop lands in the slot the shift just vacated
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH - 1; i++)
            if (push && wr == CW'(i)) data[i] <= in_data;
            else if (pop) data[i] <= data[i+1];
        if (push && wr == CW'(DEPTH - 1)) data[DEPTH-1] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            vld   <= '0;
        end else if (flush) begin
            count <= '0;
            vld   <= '0;
        end else begin
            count <= cnt_n;
            vld   <= (DEPTH'(1) << cnt_n) - DEPTH'(1);
        end
    end
endmodule

// File: rtl/srq_rr_mc.sv
// srq_rr_mc: NUM_CH compacting lanes sharing one output through a locking round-robin arbiter
module srq_rr_mc import srq_rr_pkg::*; #(
    parameter int WIDTH        = 1024,
    parameter int DEPTH        = 4,
    parameter int NUM_CH       = 4,
    parameter int FALL_THROUGH = 0,
    parameter int AF_THRESH    = DEPTH - 1,
    localparam int CHW         = chw_of(NUM_CH),
    localparam int CW          = cw_of(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH-1:0]       flush,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CHW-1:0]          out_ch,
    input  logic                    out_ready,
    output logic [NUM_CH*CW-1:0]    count,
    output logic [NUM_CH-1:0]       almost_full
);
    logic [CW-1:0]     cnt     [NUM_CH];
    logic [WIDTH-1:0]  head    [NUM_CH];
    logic [WIDTH-1:0]  lane_in [NUM_CH];
    logic [NUM_CH-1:0] hv, rdy, elig, push, pop;
    logic [CHW-1:0]    gnt, ptr, lock_ch;
    logic              lock, hs;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign lane_in[c]           = in_data[c*WIDTH +: WIDTH];
        assign elig[c]              = !flush[c] && (hv[c] || (FALL_THROUGH != 0 && in_valid[c] && rdy[c]));
        assign pop[c]               = hs && gnt == CHW'(c) && hv[c];
        // a granted empty lane is a fall-through: the entry leaves now and is not stored
        assign push[c]              = in_valid[c] && rdy[c] && !(hs && gnt == CHW'(c) && !hv[c]);
        assign count[c*CW +: CW]    = cnt[c];
        assign almost_full[c]       = cnt[c] >= CW'(AF_THRESH);
        srq_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .push      (push[c]),
            .pop       (pop[c]),
            .flush     (flush[c]),
            .in_data   (lane_in[c]),
            .count     (cnt[c]),
            .head_data (head[c]),
            .head_valid(hv[c]),
            .ready     (rdy[c])
        );
    end

    assign in_ready  = rdy;
    assign out_valid = |elig;
    assign hs        = out_valid && out_ready;
    assign out_ch    = gnt;
    assign out_data  = hv[gnt] ? head[gnt] : lane_in[gnt];

    always_comb begin
        gnt = '0;
        if (lock && elig[lock_ch]) gnt = lock_ch;
        else
            for (int k = NUM_CH - 1; k >= 0; k--)
                if (elig[(ch_idx_t'(ptr) + ch_idx_t'(k)) % NUM_CH])
                    gnt = CHW'((ch_idx_t'(ptr) + ch_idx_t'(k)) % NUM_CH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            lock    <= 1'b0;
            lock_ch <= '0;
        end else begin
            lock    <= out_valid && !out_ready;
            lock_ch <= gnt;
            if (hs) ptr <= (gnt == CHW'(NUM_CH - 1)) ? '0 : gnt + CHW'(1);
        end
    end
endmodule

// File: tb/tb_srq_rr_mc.sv
// tb_srq_rr_mc: scoreboard bench for srq_rr_mc, registered and fall-through builds
module tb_srq_rr_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid, in_ready, flush, almost_full;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic [11:0] count;

    logic [3:0]  ft_in_valid, ft_in_ready, ft_almost_full;
    logic [31:0] ft_in_data;
    logic        ft_out_valid, ft_out_ready;
    logic [7:0]  ft_out_data;
    logic [1:0]  ft_out_ch;
    logic [11:0] ft_count;

    int checks = 0;
    int failures = 0;
    logic [9:0] q[$];
    logic [9:0] e;

    always #5 clk = ~clk;

    srq_rr_mc #(.WIDTH(8), .DEPTH(4), .NUM_CH(4), .FALL_THROUGH(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .count(count), .almost_full(almost_full)
    );

    srq_rr_mc #(.WIDTH(8), .DEPTH(4), .NUM_CH(4), .FALL_THROUGH(1)) dut_ft (
        .clk(clk), .rst(rst), .in_valid(ft_in_valid), .in_data(ft_in_data), .in_ready(ft_in_ready),
        .flush(4'b0), .out_valid(ft_out_valid), .out_data(ft_out_data), .out_ch(ft_out_ch),
        .out_ready(ft_out_ready), .count(ft_count), .almost_full(ft_almost_full)
    );

    function automatic logic [2:0] cnt_of(input logic [11:0] v, input int c);
        return v[c*3 +: 3];
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, x);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic [7:0] d);
        in_valid[c] = 1'b1;
        in_data[c*8 +: 8] = d;
    endtask

    task automatic expect_out(input logic [1:0] c, input logic [7:0] d);
        q.push_back({c, d});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got ch=%0d data=%0h exp=none", out_ch, out_data);
            end else begin
                e = q.pop_front();
                if ({out_ch, out_data} !== e) begin
                    failures++;
                    $display("FAIL sb_out got ch=%0d data=%0h exp ch=%0d data=%0h",
                             out_ch, out_data, e[9:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_valid = '0; in_data = '0; flush = '0; out_ready = 1'b0;
        ft_in_valid = '0; ft_in_data = '0; ft_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // reset with data held in lanes
        drive(1, 8'h77); drive(2, 8'h78);
        cyc();
        in_valid = '0;
        chk("pre_rst_cnt1", cnt_of(count, 1), 1);
        chk("pre_rst_ovalid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_inready", in_ready, 4'hf);
        chk("rst_af", almost_full, 0);
        chk("rst_och", out_ch, 0);
        cyc();
        rst = 1'b1;

        // fill lane 0 to full under backpressure
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'hA0 + 8'(i));
            cyc();
            if (i == 1) chk("af_at2", almost_full[0], 0);
            if (i == 2) chk("af_at3", almost_full[0], 1);
        end
        chk("full_cnt", cnt_of(count, 0), 4);
        chk("full_inready", in_ready[0], 0);
        drive(0, 8'hA4);
        cyc();
        in_valid = '0;
        chk("refused_cnt", cnt_of(count, 0), 4);
        for (int i = 0; i < 4; i++) expect_out(2'd0, 8'hA0 + 8'(i));
        out_ready = 1'b1;
        repeat (4) cyc();
        out_ready = 1'b0;
        chk("drain_cnt", cnt_of(count, 0), 0);

        // round robin between lanes 0 and 2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h10 + 8'(i)); drive(2, 8'h20 + 8'(i));
            cyc();
        end
        in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            expect_out(2'd0, 8'h10 + 8'(i));
            expect_out(2'd2, 8'h20 + 8'(i));
        end
        out_ready = 1'b1;
        repeat (6) cyc();
        @(negedge clk);
        chk("rr_empty", out_valid, 0);
        out_ready = 1'b0;

        // grant lock under backpressure
        do_reset();
        drive(1, 8'h31);
        cyc();
        in_valid = '0;
        drive(0, 8'h30); drive(2, 8'h32);
        @(negedge clk);
        chk("bp_first_ch", out_ch, 1);
        cyc();
        in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_lock_ch", out_ch, 1);
            chk("bp_lock_data", out_data, 8'h31);
            cyc();
        end
        expect_out(2'd1, 8'h31); expect_out(2'd2, 8'h32); expect_out(2'd0, 8'h30);
        out_ready = 1'b1;
        repeat (3) cyc();
        out_ready = 1'b0;

        // push+pop at count 2 on lane 3
        drive(3, 8'h40); cyc();
        drive(3, 8'h41); cyc();
        drive(3, 8'h42);
        expect_out(2'd3, 8'h40);
        out_ready = 1'b1;
        cyc();
        in_valid = '0;
        expect_out(2'd3, 8'h41); expect_out(2'd3, 8'h42);
        chk("pp_cnt", cnt_of(count, 3), 2);
        repeat (2) cyc();
        out_ready = 1'b0;
        chk("pp_drain", cnt_of(count, 3), 0);

        // flush lane 3 with a concurrent push; lane 2 pushes alongside
        drive(3, 8'h50); cyc();
        drive(3, 8'h51); cyc();
        in_valid = '0;
        flush = 4'b1000;
        drive(3, 8'h52); drive(2, 8'h60);
        chk("fl_inready", in_ready[3], 1);
        @(negedge clk);
        chk("fl_ovalid", out_valid, 0);
        cyc();
        flush = '0; in_valid = '0;
        chk("fl_cnt3", cnt_of(count, 3), 0);
        chk("fl_cnt2", cnt_of(count, 2), 1);
        expect_out(2'd2, 8'h60);
        out_ready = 1'b1;
        repeat (2) cyc();
        out_ready = 1'b0;
        chk("fl_end_cnt", count, 0);

        // fall-through build
        ft_in_valid = 4'b0010; ft_in_data[15:8] = 8'h55; ft_out_ready = 1'b1;
        #1;
        chk("ft_valid", ft_out_valid, 1);
        chk("ft_data", ft_out_data, 8'h55);
        chk("ft_ch", ft_out_ch, 1);
        cyc();
        ft_in_valid = '0;
        chk("ft_cnt1", cnt_of(ft_count, 1), 0);
        ft_out_ready = 1'b0;
        ft_in_valid = 4'b0100; ft_in_data[23:16] = 8'h66;
        #1;
        chk("ft_bp_ch", ft_out_ch, 2);
        cyc();
        ft_in_valid = '0;
        chk("ft_stored_cnt", cnt_of(ft_count, 2), 1);
        chk("ft_stored_data", ft_out_data, 8'h66);
        ft_out_ready = 1'b1;
        cyc();
        ft_out_ready = 1'b0;
        chk("ft_drain_cnt", cnt_of(ft_count, 2), 0);

        chk("sb_leftover", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/srq_rr_mc.md
Name: srq_rr_mc

Overview:
- Multi-channel successor to the single-lane shift-register queue: NUM_CH independent compacting shift-register lanes.
- All lanes share one output port, selected by a round-robin arbiter.
- Sits between the command/data front end and the per-bank scheduler, so one block buffers per-bank traffic and feeds one consumer fairly.
- Adds valid/ready handshakes, per-lane occupancy, almost-full, per-lane flush, and an optional fall-through mode.

Parameters:
- WIDTH, 1024, payload bits per entry.
- DEPTH, 4, entries per lane (>=2).
- NUM_CH, 4, number of lanes (>=1).
- FALL_THROUGH, 0, 1 = an empty lane's push may leave the block in the same cycle.
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  NUM_CH  per-lane push request
- in_data  in  NUM_CH*WIDTH  per-lane payload, lane c at [c*WIDTH +: WIDTH]
- in_ready  out  NUM_CH  lane c can accept
- flush  in  NUM_CH  per-lane synchronous clear
- out_valid  out  1  an entry is presented
- out_data  out  WIDTH  presented payload
- out_ch  out  CHW  lane index of presented entry
- out_ready  in  1  consumer accepts
- count  out  NUM_CH*CW  per-lane occupancy
- almost_full  out  NUM_CH  per-lane count >= AF_THRESH

Behaviour:
- CHW = max(1, $clog2(NUM_CH)); CW = $clog2(DEPTH+1).
- Reset (async, rst=0):
  - all counts 0, all valid bits 0, RR pointer 0, grant lock cleared;
  - out_valid=0, out_ch=0, almost_full=0;
  - in_ready=1 for every lane.
  - Data registers are not reset.
  - Reset mid-traffic discards all entries immediately.
- Lane storage is compacting: slot 0 holds the oldest entry and slots 0..count-1 are valid.
- Push (in_valid[c] && in_ready[c]):
  - writes slot count, or slot count-1 if lane c pops in the same cycle;
  - count +1.
- Pop (lane c granted && out_valid && out_ready):
  - all slots shift down by one; count -1.
- Simultaneous push+pop on a lane: count unchanged, order preserved.
- in_ready[c] = (count[c] < DEPTH), registered-state only. There is no combinational path from out_ready to in_ready, so a full lane refuses a push even when it pops that cycle.
- Latency, FALL_THROUGH=0: an entry pushed into an empty lane is visible at the head in the next cycle.
- FALL_THROUGH=1: if lane c is empty and in_valid[c]=1, lane c is eligible that cycle.
  - If granted with out_ready=1, in_data[c] goes directly to out_data and is not stored; count stays 0.
  - If not popped, the entry is stored normally.
- Eligibility: lane c is eligible if count[c]>0, or (FALL_THROUGH && in_valid[c] && in_ready[c]). Lanes with flush[c]=1 are not eligible.
- Arbiter:
  - grant = first eligible lane searching from the RR pointer upward, wrapping at NUM_CH-1 -> 0;
  - out_valid = any eligible lane;
  - out_data = granted lane's head; out_ch = granted index.
- Stability:
  - if out_valid && !out_ready, the grant locks;
  - out_ch and out_data must not change next cycle, even if a lower-numbered lane becomes eligible;
  - the lock releases on handshake or when the locked lane is flushed.
- Pointer update: on handshake, pointer = grant+1 (mod NUM_CH). Otherwise it is unchanged.
- Flush[c]:
  - next cycle count[c]=0 and the lane's valid bits are cleared;
  - a push to lane c in the same cycle is discarded (flush wins);
  - in_ready[c] still reflects pre-flush state;
  - other lanes are unaffected.
- almost_full[c] and count[c] are registered-state outputs with no combinational dependency on inputs.

Decomposition:
- Package srq_rr_pkg: function computing CW/CHW from DEPTH/NUM_CH, and a typedef for channel index.
- Sub-module srq_lane: one compacting lane with push/pop/flush, count, head_data, head_valid.
- Top level: NUM_CH srq_lane instances plus round-robin arbiter, grant lock, and output mux.

Test Plan:
1. Reset: assert rst=0 with lanes holding data -> out_valid=0, all counts 0, in_ready=all 1s immediately.
2. Fill lane 0 (DEPTH=4) with 0xA0..0xA3, out_ready=0 -> count[0]=4, almost_full[0]=1 after the 3rd push, in_ready[0]=0; a 5th push is refused and count stays 4.
3. Round-robin: lane0={0x10,0x11,0x12}, lane2={0x20,0x21,0x22}, out_ready=1 -> out_ch sequence 0,2,0,2,0,2 and data 0x10,0x20,0x11,0x21,0x12,0x22.
4. Backpressure: lane1 presented with out_ready=0 for 3 cycles while lane0 becomes eligible -> out_ch stays 1 and out_data is unchanged; with out_ready=1, lane1 pops and the next grant is lane 2 or wraps to 0.
5. Push+pop at count=2 on lane 3 -> count stays 2 and FIFO order is preserved. Flush lane 3 with a concurrent push -> count[3]=0 next cycle and the pushed data never appears.
6. FALL_THROUGH=1, all lanes empty, in_valid[1]=1 with 0x55, out_ready=1 -> out_valid=1, out_data=0x55, out_ch=1 in the same cycle; count[1] stays 0.
